mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports clk (input, 1, rising-edge system clock) and reset (input, 1, synchronous active-high reset); one clock, reset sampled only on posedge clk.
REQ-002 SHALL have fetch port: ifReq in 1 (fetch request); ifAddr in 32 (word address); ifValid out 1 (one-cycle completion pulse); ifData out 32 (fetched word).
REQ-003 SHALL have data port: dReq in 1; dWrite in 1; dSize in 2 (00 byte, 01 half, 10 word); dSign in 1; dAddr in 32; dWData in 32; dDone out 1 (one-cycle completion pulse); dRData out 32; dErr out 1 (error pulse, Configuration only).
REQ-004 SHALL have memory side: memExecute out 1; memWrite out 1; memSize out 2; memSign out 1; memAddress out 32; memWData out 32 (drives memory write data); memReady in 1; dataReady in 1; memRData in 32 (memory read data).

Function
REQ-005 SHALL use four states: IDLE, ISSUE, WAIT, RESP.
REQ-006 IDLE: when memReady=1 and any request pending, SHALL arbitrate, latch winner's attributes into memory-side outputs, go ISSUE next cycle.
REQ-007 Arbitration: data port wins over fetch, except fetch wins if it lost the previous arbitration while pending; both pending continuously -> grants alternate D,F,D,F.
REQ-008 ISSUE: memExecute=1; SHALL hold memExecute and all memory-side outputs stable until memReady samples 0, then go WAIT with memExecute=0.
REQ-009 WAIT: memory-side outputs SHALL remain stable; on first cycle memReady=1, SHALL latch memRData (reads) and go RESP.
REQ-010 RESP: SHALL pulse ifValid or dDone for exactly one cycle, with ifData/dRData holding the latched word, then return IDLE.
REQ-011 Fetch SHALL always issue memWrite=0, memSize=10, memSign=0, memAddress=ifAddr.
REQ-012 Data writes: dRData SHALL not update; dataReady ignored for writes; completion solely on memReady rising in WAIT.
REQ-013 Reads SHALL complete regardless of dataReady level; dataReady only qualifies a debug assertion (dataReady=1 expected on read completion).
REQ-014 Requesters hold req and attributes stable until their pulse; a req still high in the cycle after its pulse SHALL be treated as a new request.
REQ-015 ifData/dRData SHALL retain last value between completions; minimum IDLE->RESP latency is 3 cycles plus memory latency.
REQ-016 A request arriving while busy SHALL wait; never two transactions outstanding.

Reset
REQ-017 On reset: state IDLE; memExecute, memWrite, memSign, ifValid, dDone, dErr = 0; memSize = 00; memAddress, memWData, ifData, dRData = 0; fairness flag cleared (data priority).
REQ-018 Reset mid-transaction SHALL abandon it with no completion pulse; the memory is reset by the same signal.

Configuration
REQ-019 Macro MEM_ALIGN_CHECK_EN defined: in IDLE, data request with dSize=01 and dAddr[0]=1, dSize=10 and dAddr[1:0]!=0, or dSize=11 SHALL not be issued; next cycle dErr=1 and dDone=1 for one cycle; dRData unchanged; counts as a data grant for fairness.
REQ-020 Macro undefined: no check, dErr tied 0, all data requests issued unmodified.

Verification
REQ-021 Fetch only: ifReq=1, ifAddr=0x100, memory returns 0xDEADBEEF -> one ifValid pulse, ifData=0xDEADBEEF, memWrite=0, memSize=10 throughout.
REQ-022 Data write byte: dWrite=1, dSize=00, dAddr=0x203, dWData=0xAB -> memExecute held until memReady=0, memWData=0xAB stable through WAIT, one dDone pulse, dRData unchanged.
REQ-023 Both pending continuously for 4 transactions -> grant order D,F,D,F; no memory-side output change between ISSUE and RESP.
REQ-024 Signed half read dAddr=0x10000, memory returns 0xFFFF8000 -> dDone pulse, dRData=0xFFFF8000, memSign=1 during transaction.
REQ-025 Reset asserted in WAIT -> next cycle all outputs at reset values, no ifValid/dDone pulse; fresh request afterwards completes normally.
REQ-026 With MEM_ALIGN_CHECK_EN: dSize=10, dAddr=0x2 -> memExecute never asserts, dErr=dDone=1 one cycle; without macro same stimulus issued to memory.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch requester
// and a load/store requester. It runs one transaction at a time through
// IDLE -> ISSUE -> WAIT -> RESP and completes it with a one-cycle pulse.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   ifReq/ifAddr          fetch request and word address
//   ifValid/ifData        fetch completion pulse and fetched word
//   dReq/dWrite/dSize/    data request, direction, size (00 byte, 01 half,
//   dSign/dAddr/dWData    10 word), sign-extend flag, address, write data
//   dDone/dRData/dErr     data completion pulse, read word, alignment error
//   memExecute..memWData  memory command, held stable for the transaction
//   memReady/dataReady/   memory handshake and read data
//   memRData
//
// Build option: define MEM_ALIGN_CHECK_EN to reject misaligned data accesses
// (and dSize=11) in IDLE with a dErr+dDone pulse instead of issuing them.
// Left undefined, dErr is tied low and every data request goes to memory.
//
// state  | meaning
// S_IDLE | wait for memReady and a pending request, arbitrate, latch command
// S_ISSUE| memExecute high until memory drops memReady (accepted)
// S_WAIT | command held; first memReady=1 completes, read data latched
// S_RESP | one-cycle ifValid or dDone pulse

module mem_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic        ifReq,
  input  logic [31:0] ifAddr,
  output logic        ifValid,
  output logic [31:0] ifData,
  input  logic        dReq,
  input  logic        dWrite,
  input  logic [1:0]  dSize,
  input  logic        dSign,
  input  logic [31:0] dAddr,
  input  logic [31:0] dWData,
  output logic        dDone,
  output logic [31:0] dRData,
  output logic        dErr,
  output logic        memExecute,
  output logic        memWrite,
  output logic [1:0]  memSize,
  output logic        memSign,
  output logic [31:0] memAddress,
  output logic [31:0] memWData,
  input  logic        memReady,
  input  logic        dataReady,
  input  logic [31:0] memRData
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t state, state_nxt;
  logic   grant_d;      // current transaction belongs to the data port
  logic   fetch_lost;   // fetch was pending and lost the last arbitration
  logic   pick_d;
  logic   arb_go;
  logic   misaligned;

  // Data has priority unless fetch was starved last round.
  assign pick_d = dReq & ~(ifReq & fetch_lost);
  assign arb_go = (state == S_IDLE) & memReady & (ifReq | dReq);

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q;

  always_comb begin
    misaligned = 1'b0;
    case (dSize)
      2'b01:   misaligned = dAddr[0];
      2'b10:   misaligned = |dAddr[1:0];
      2'b11:   misaligned = 1'b1;
      default: misaligned = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)       err_q <= 1'b0;
    else if (arb_go) err_q <= pick_d & misaligned;
  end

  assign dErr = (state == S_RESP) & err_q;
`else
  assign misaligned = 1'b0;
  assign dErr       = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (arb_go) state_nxt = (pick_d & misaligned) ? S_RESP : S_ISSUE;
      S_ISSUE: if (!memReady) state_nxt = S_WAIT;
      S_WAIT:  if (memReady) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // outputs decoded from state
  always_comb begin
    memExecute = (state == S_ISSUE);
    ifValid    = (state == S_RESP) & ~grant_d;
    dDone      = (state == S_RESP) &  grant_d;
  end

  // command latch, arbitration history and read-data capture
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_d    <= 1'b0;
      fetch_lost <= 1'b0;
      memWrite   <= 1'b0;
      memSize    <= 2'b00;
      memSign    <= 1'b0;
      memAddress <= '0;
      memWData   <= '0;
      ifData     <= '0;
      dRData     <= '0;
    end else begin
      if (arb_go) begin
        grant_d    <= pick_d;
        fetch_lost <= pick_d & ifReq;
        if (pick_d) begin
          // A rejected access leaves the memory command untouched.
          if (!misaligned) begin
            memWrite   <= dWrite;
            memSize    <= dSize;
            memSign    <= dSign;
            memAddress <= dAddr;
            memWData   <= dWData;
          end
        end else begin
          memWrite   <= 1'b0;
          memSize    <= 2'b10;
          memSign    <= 1'b0;
          memAddress <= ifAddr;
        end
      end
      if ((state == S_WAIT) && memReady && !memWrite) begin
        if (grant_d) dRData <= memRData;
        else         ifData <= memRData;
      end
    end
  end

  // Memory is expected to present valid read data when it completes a read.
  a_read_data_ready: assert property (@(posedge clk) disable iff (reset)
    ((state == S_WAIT) && memReady && !memWrite) |-> dataReady);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. The bench plays the memory: it watches
// memExecute, drops memReady to accept, waits a chosen latency, then raises
// memReady with read data. Expected values are written out by hand.
// Compile with or without MEM_ALIGN_CHECK_EN to match the RTL build.

module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ifReq;
  logic [31:0] ifAddr;
  logic        ifValid;
  logic [31:0] ifData;
  logic        dReq, dWrite, dSign;
  logic [1:0]  dSize;
  logic [31:0] dAddr, dWData;
  logic        dDone, dErr;
  logic [31:0] dRData;
  logic        memExecute, memWrite, memSign;
  logic [1:0]  memSize;
  logic [31:0] memAddress, memWData;
  logic        memReady, dataReady;
  logic [31:0] memRData;

  int tests_run    = 0;
  int tests_failed = 0;

  // captured by serve
  logic [67:0] snap;  // {memWrite, memSize, memSign, memAddress, memWData}
  bit stable_ok, exec_hold_ok, exec_low_ok;
  bit pulse_if, pulse_d, pulse_err, tail_if, tail_d;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifValid(ifValid), .ifData(ifData),
    .dReq(dReq), .dWrite(dWrite), .dSize(dSize), .dSign(dSign),
    .dAddr(dAddr), .dWData(dWData), .dDone(dDone), .dRData(dRData), .dErr(dErr),
    .memExecute(memExecute), .memWrite(memWrite), .memSize(memSize),
    .memSign(memSign), .memAddress(memAddress), .memWData(memWData),
    .memReady(memReady), .dataReady(dataReady), .memRData(memRData)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cmp_snap();
    if ({memWrite, memSize, memSign, memAddress, memWData} !== snap) stable_ok = 0;
  endtask

  // Serve one transaction: hold = extra ISSUE cycles with memReady high,
  // lat = WAIT cycles before completing. Ends at the negedge after RESP.
  task automatic serve(input logic [31:0] rdata, input int lat, input int hold);
    int n = 0;
    bit seen = 0;
    memReady = 1'b1;
    pulse_if = 0; pulse_d = 0; pulse_err = 0; tail_if = 0; tail_d = 0;
    stable_ok = 0; exec_hold_ok = 0; exec_low_ok = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      seen = memExecute;
      n++;
    end
    if (!seen) begin
      check("exec_timeout", 64'd0, 64'd1);
      return;
    end
    snap = {memWrite, memSize, memSign, memAddress, memWData};
    stable_ok = 1; exec_hold_ok = 1;
    repeat (hold) begin
      @(negedge clk);
      if (!memExecute) exec_hold_ok = 0;
      cmp_snap();
    end
    memReady = 1'b0;
    @(negedge clk);
    exec_low_ok = !memExecute;
    cmp_snap();
    repeat (lat) begin
      @(negedge clk);
      if (memExecute) exec_low_ok = 0;
      cmp_snap();
    end
    memReady = 1'b1; memRData = rdata; dataReady = 1'b1;
    @(negedge clk);
    pulse_if = ifValid; pulse_d = dDone; pulse_err = dErr;
    cmp_snap();
    @(negedge clk);
    tail_if = ifValid; tail_d = dDone;
    dataReady = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ifReq = 0; ifAddr = 0;
    dReq = 0; dWrite = 0; dSize = 0; dSign = 0; dAddr = 0; dWData = 0;
    memReady = 1'b1; dataReady = 1'b0; memRData = 0;
    repeat (3) @(negedge clk);

    // reset values
    check("rst_ctrl", {memExecute, memWrite, memSize, memSign, ifValid, dDone, dErr}, 64'd0);
    check("rst_addr", memAddress, 64'd0);
    check("rst_wdata", memWData, 64'd0);
    check("rst_rdata", {ifData, dRData}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // fetch only
    ifReq = 1; ifAddr = 32'h100;
    serve(32'hDEAD_BEEF, 2, 0);
    ifReq = 0;
    check("f_pulse", {pulse_if, pulse_d, pulse_err}, 64'b100);
    check("f_tail", {tail_if, tail_d}, 64'd0);
    check("f_data", ifData, 64'hDEAD_BEEF);
    check("f_attr", snap[67:32], {1'b0, 2'b10, 1'b0, 32'h100});
    check("f_stable", stable_ok, 64'd1);
    check("f_exec_low", exec_low_ok, 64'd1);

    // byte write, memory holds memReady high two extra cycles in ISSUE
    dReq = 1; dWrite = 1; dSize = 2'b00; dSign = 0; dAddr = 32'h203; dWData = 32'hAB;
    serve(32'h1234_5678, 3, 2);
    dReq = 0;
    check("w_pulse", {pulse_if, pulse_d, tail_d}, 64'b010);
    check("w_exec_hold", exec_hold_ok, 64'd1);
    check("w_exec_low", exec_low_ok, 64'd1);
    check("w_attr", snap[67:32], {1'b1, 2'b00, 1'b0, 32'h203});
    check("w_wdata", snap[31:0], 64'hAB);
    check("w_stable", stable_ok, 64'd1);
    check("w_rdata_kept", {ifData, dRData}, {32'hDEAD_BEEF, 32'h0});

    // signed half read
    dReq = 1; dWrite = 0; dSize = 2'b01; dSign = 1; dAddr = 32'h1_0000; dWData = 0;
    serve(32'hFFFF_8000, 1, 0);
    dReq = 0;
    check("r_pulse", {pulse_if, pulse_d, pulse_err}, 64'b010);
    check("r_data", dRData, 64'hFFFF_8000);
    check("r_attr", snap[67:32], {1'b0, 2'b01, 1'b1, 32'h1_0000});
    check("r_stable", stable_ok, 64'd1);

    // both pending continuously: D, F, D, F
    ifReq = 1; ifAddr = 32'h400;
    dReq = 1; dWrite = 0; dSize = 2'b10; dSign = 0; dAddr = 32'h500; dWData = 32'h55;
    for (int i = 0; i < 4; i++) begin
      serve(32'h1111_0000 + i, 1, 0);
      if (i == 3) begin ifReq = 0; dReq = 0; end
      if (i % 2 == 0)
        check($sformatf("alt_grant%0d", i), {pulse_d, pulse_if, snap[63:32]}, {1'b1, 1'b0, 32'h500});
      else
        check($sformatf("alt_grant%0d", i), {pulse_d, pulse_if, snap[63:32]}, {1'b0, 1'b1, 32'h400});
      check($sformatf("alt_stable%0d", i), stable_ok, 64'd1);
    end
    check("alt_data", {ifData, dRData}, {32'h1111_0003, 32'h1111_0002});

    // reset while in WAIT
    ifReq = 1; ifAddr = 32'h600;
    begin
      int n = 0;
      bit seen = 0;
      while (!seen && n < 20) begin
        @(negedge clk);
        seen = memExecute;
        n++;
      end
      check("rs_exec_seen", seen, 64'd1);
    end
    memReady = 0;
    @(negedge clk);
    reset = 1; ifReq = 0; memReady = 1;
    @(negedge clk);
    check("rs_ctrl", {memExecute, memWrite, memSize, memSign, ifValid, dDone, dErr}, 64'd0);
    check("rs_addr", memAddress, 64'd0);
    check("rs_wdata", memWData, 64'd0);
    check("rs_rdata", {ifData, dRData}, 64'd0);
    reset = 0;
    begin
      bit any_pulse = 0;
      repeat (4) begin
        @(negedge clk);
        if (ifValid || dDone || memExecute) any_pulse = 1;
      end
      check("rs_quiet", any_pulse, 64'd0);
    end
    ifReq = 1; ifAddr = 32'h700;
    serve(32'hCAFE_F00D, 1, 0);
    ifReq = 0;
    check("rs_fresh", {pulse_if, ifData}, {1'b1, 32'hCAFE_F00D});

    // misaligned word read
    dReq = 1; dWrite = 0; dSize = 2'b10; dSign = 0; dAddr = 32'h2;
`ifdef MEM_ALIGN_CHECK_EN
    begin
      bit exec_seen = 0;
      int done_cnt = 0, err_cnt = 0;
      repeat (6) begin
        @(negedge clk);
        if (memExecute) exec_seen = 1;
        if (dErr) err_cnt++;
        if (dDone) begin
          done_cnt++;
          dReq = 0;
        end
      end
      dReq = 0;
      check("al_no_exec", exec_seen, 64'd0);
      check("al_done_cnt", done_cnt, 64'd1);
      check("al_err_cnt", err_cnt, 64'd1);
      check("al_rdata_kept", dRData, 64'd0);
    end
`else
    serve(32'h0BAD_F00D, 0, 0);
    dReq = 0;
    check("al_pulse", {pulse_if, pulse_d, pulse_err}, 64'b010);
    check("al_attr", snap[67:32], {1'b0, 2'b10, 1'b0, 32'h2});
    check("al_rdata", dRData, 64'h0BAD_F00D);
`endif

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
